// File: rtl/button_repeat_if.sv
// Button event bundle: tick strobe and debounced level in, registered press/repeat/release/step/held out.
// repeat/release are SV keywords, so those pulses carry a _pulse suffix.
interface button_repeat_if;
  logic clk_en;
  logic level;
  logic press;
  logic repeat_pulse;
  logic release_pulse;
  logic step;
  logic held;

  modport master (
    output clk_en, level,
    input  press, repeat_pulse, release_pulse, step, held
  );

  modport slave (
    input  clk_en, level,
    output press, repeat_pulse, release_pulse, step, held
  );
endinterface

// File: rtl/button_repeat.sv
// Press/auto-repeat/release pulse generator for one debounced button, timed in clk_en ticks.
// Latency: 1 clk from the sampling tick to every output. No backpressure; pulses last one clk.
module button_repeat #(
  parameter int DELAY_TICKS = 32,
  parameter int RATE_TICKS  = 8,
  parameter int CNT_W       = 8,
  parameter bit REPEAT_EN   = 1'b1
) (
  input  logic           clk,
  input  logic           reset_n,
  button_repeat_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DELAY  = 2'd1,
    S_REPEAT = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] DLY_LAST  = CNT_W'(DELAY_TICKS - 1);
  localparam logic [CNT_W-1:0] RATE_LAST = CNT_W'(RATE_TICKS - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_d, rpt_d, rls_d, held_d;
  logic             press_q, rpt_q, rls_q, step_q, held_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
    rpt_d   = 1'b0;
    rls_d   = 1'b0;
    if (bus.clk_en) begin
      case (state_q)
        S_IDLE: begin
          if (bus.level) begin
            press_d = 1'b1;
            cnt_d   = '0;
            state_d = S_DELAY;
          end
        end
        S_DELAY: begin
          if (!bus.level) begin
            rls_d   = 1'b1;
            state_d = S_IDLE;
          end else if (cnt_q == DLY_LAST) begin
            // Without auto-repeat the counter parks at its last value.
            if (REPEAT_EN) begin
              rpt_d   = 1'b1;
              cnt_d   = '0;
              state_d = S_REPEAT;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_REPEAT: begin
          // Release wins over a repeat falling due on the same tick.
          if (!bus.level) begin
            rls_d   = 1'b1;
            state_d = S_IDLE;
          end else if (cnt_q == RATE_LAST) begin
            rpt_d = 1'b1;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    // held covers the press cycle through the release cycle inclusive.
    held_d = (state_d != S_IDLE) || rls_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      press_q <= 1'b0;
      rpt_q   <= 1'b0;
      rls_q   <= 1'b0;
      step_q  <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
      rpt_q   <= rpt_d;
      rls_q   <= rls_d;
      step_q  <= press_d | rpt_d;
      held_q  <= held_d;
    end
  end

  assign bus.press         = press_q;
  assign bus.repeat_pulse  = rpt_q;
  assign bus.release_pulse = rls_q;
  assign bus.step          = step_q;
  assign bus.held          = held_q;

endmodule

// File: tb/tb_button_repeat.sv
// Directed bench: two instances (auto-repeat on/off, DELAY_TICKS=4, RATE_TICKS=2) driven in lockstep.
module tb_button_repeat;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  button_repeat_if bi ();
  button_repeat_if bi_nr ();

  button_repeat #(.DELAY_TICKS(4), .RATE_TICKS(2), .CNT_W(8), .REPEAT_EN(1'b1)) u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bi)
  );

  button_repeat #(.DELAY_TICKS(4), .RATE_TICKS(2), .CNT_W(8), .REPEAT_EN(1'b0)) u_dut_nr (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bi_nr)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Outputs captured one half-cycle after each tick edge.
  logic [31:0] p, r, l, s, h;
  logic [31:0] p2, r2, l2, h2;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // One clk_en tick with the given level, then `gap` cycles without clk_en.
  // During the gap the level is inverted: it must be ignored, and no pulse may stay high.
  task automatic tick(input logic lvl, input int gap);
    bi.level     = lvl;
    bi_nr.level  = lvl;
    bi.clk_en    = 1'b1;
    bi_nr.clk_en = 1'b1;
    @(negedge clk);
    p  = 32'(bi.press);
    r  = 32'(bi.repeat_pulse);
    l  = 32'(bi.release_pulse);
    s  = 32'(bi.step);
    h  = 32'(bi.held);
    p2 = 32'(bi_nr.press);
    r2 = 32'(bi_nr.repeat_pulse);
    l2 = 32'(bi_nr.release_pulse);
    h2 = 32'(bi_nr.held);
    bi.clk_en    = 1'b0;
    bi_nr.clk_en = 1'b0;
    for (int g = 0; g < gap; g++) begin
      bi.level    = ~lvl;
      bi_nr.level = ~lvl;
      @(negedge clk);
      if (g == 0) begin
        chk("width_pulses", 32'({bi.press, bi.repeat_pulse, bi.release_pulse, bi.step}), 32'd0);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got no end of run, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int steps;
    int np, nr, nl;

    reset_n      = 1'b0;
    bi.clk_en    = 1'b1;
    bi.level     = 1'b1;
    bi_nr.clk_en = 1'b1;
    bi_nr.level  = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_outputs", 32'({bi.press, bi.repeat_pulse, bi.release_pulse, bi.step, bi.held}), 32'd0);
    chk("rst_state", 32'(u_dut.state_q), 32'd0);
    chk("rst_cnt", 32'(u_dut.cnt_q), 32'd0);
    bi.clk_en    = 1'b0;
    bi.level     = 1'b0;
    bi_nr.clk_en = 1'b0;
    bi_nr.level  = 1'b0;
    reset_n      = 1'b1;
    tick(1'b0, 0);
    tick(1'b0, 0);
    chk("idle_quiet", p | r | l | s | h, 32'd0);

    // 1: level high ticks 0..9, low at 10, clk_en every cycle.
    steps = 0;
    for (int i = 0; i <= 10; i++) begin
      tick(i < 10, 0);
      chk("s1_press", p, 32'(i == 0));
      chk("s1_repeat", r, 32'(i == 4 || i == 6 || i == 8));
      chk("s1_release", l, 32'(i == 10));
      chk("s1_step", s, 32'(i == 0 || i == 4 || i == 6 || i == 8));
      steps += int'(s);
    end
    chk("s1_step_count", 32'(steps), 32'd4);
    chk("s1_held_rel_cycle", h, 32'd1);
    @(negedge clk);
    chk("s1_held_after", 32'(bi.held), 32'd0);

    // 2: clk_en every 3rd cycle, level held 5 ticks.
    for (int i = 0; i <= 5; i++) begin
      tick(i < 5, 2);
      chk("s2_press", p, 32'(i == 0));
      chk("s2_repeat", r, 32'(i == 4));
      chk("s2_release", l, 32'(i == 5));
    end

    // 3: single-tick press.
    tick(1'b1, 0);
    chk("s3_press", p, 32'd1);
    chk("s3_held0", h, 32'd1);
    tick(1'b0, 0);
    chk("s3_release", l, 32'd1);
    chk("s3_repeat", r, 32'd0);
    chk("s3_held1", h, 32'd1);
    @(negedge clk);
    chk("s3_held_after", 32'(bi.held), 32'd0);

    // 4: auto-repeat disabled, level held 50 ticks.
    np = 0; nr = 0; nl = 0;
    for (int i = 0; i < 50; i++) begin
      tick(1'b1, 0);
      np += int'(p2); nr += int'(r2); nl += int'(l2);
    end
    chk("s4_held", h2, 32'd1);
    chk("s4_cnt_sat", 32'(u_dut_nr.cnt_q), 32'd3);
    tick(1'b0, 0);
    np += int'(p2); nr += int'(r2); nl += int'(l2);
    chk("s4_presses", 32'(np), 32'd1);
    chk("s4_repeats", 32'(nr), 32'd0);
    chk("s4_releases", 32'(nl), 32'd1);
    tick(1'b0, 0);

    // 5: level falls on tick 6, where a repeat would be due.
    for (int i = 0; i <= 6; i++) begin
      tick(i < 6, 0);
      chk("s5_press", p, 32'(i == 0));
      chk("s5_repeat", r, 32'(i == 4));
      chk("s5_release", l, 32'(i == 6));
    end
    tick(1'b0, 0);

    // 6: reset mid-hold, level stays high.
    for (int i = 0; i <= 4; i++) begin
      tick(1'b1, 0);
      chk("s6_repeat", r, 32'(i == 4));
    end
    #2 reset_n = 1'b0;
    #1;
    chk("s6_rst_outputs", 32'({bi.press, bi.repeat_pulse, bi.release_pulse, bi.step, bi.held}), 32'd0);
    bi.level  = 1'b1;
    bi.clk_en = 1'b1;
    @(negedge clk);
    chk("s6_no_release_in_rst", 32'(bi.release_pulse), 32'd0);
    bi.clk_en = 1'b0;
    reset_n   = 1'b1;
    @(negedge clk);
    chk("s6_quiet_after_rst", 32'({bi.press, bi.release_pulse, bi.held}), 32'd0);
    tick(1'b1, 0);
    chk("s6_fresh_press", p, 32'd1);
    chk("s6_fresh_release", l, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
